// File: rtl/exec_resolve_stage_pkg.sv
// Shared constants and helpers for the execute/resolve stage.
// Holds instruction sizing, branch-offset scaling and the is_* flag layout.
package exec_resolve_stage_pkg;

  // Instruction size in bytes; fallthrough PC is pc + INSN_BYTES.
  localparam int unsigned INSN_BYTES = 4;
  // Branch immediates are in words; shift left by this to get bytes.
  localparam int unsigned BR_SHIFT   = 2;

  // Bit positions inside the instruction-flag bundle.
  localparam int unsigned FLAG_BRANCH = 0;
  localparam int unsigned FLAG_JAL    = 1;
  localparam int unsigned FLAG_LOAD   = 2;
  localparam int unsigned FLAG_STORE  = 3;
  localparam int unsigned FLAG_W      = 4;

  typedef logic [FLAG_W-1:0] insn_flags_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/exec_resolve_stage_branch_resolve.sv
// branch_resolve: purely combinational resolution of a branch or JAL.
// Produces the fallthrough PC, the resolved taken flag and target, and
// whether the front-end prediction was wrong. Non-control instructions
// are never taken and never mispredict.
module branch_resolve
  import exec_resolve_stage_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0] alu_out,
  input  logic [BIT_WIDTH-1:0] pc,
  input  logic [BIT_WIDTH-1:0] imm,
  input  logic                 is_branch,
  input  logic                 is_jal,
  input  logic                 pred_taken,
  input  logic [BIT_WIDTH-1:0] pred_target,
  output logic                 taken,
  output logic [BIT_WIDTH-1:0] target,
  output logic [BIT_WIDTH-1:0] fallthrough,
  output logic                 mispredict
);

  logic is_ctrl;

  // Resolve direction and target; JAL wins if both flags are raised.
  always_comb begin
    fallthrough = pc + BIT_WIDTH'(INSN_BYTES);
    taken       = 1'b0;
    target      = '0;
    is_ctrl     = is_branch | is_jal;
    if (is_jal) begin
      taken  = 1'b1;
      target = alu_out;
    end else if (is_branch) begin
      taken  = alu_out[0];
      target = fallthrough + (imm << BR_SHIFT);
    end
    mispredict = is_ctrl &&
                 ((taken != pred_taken) || (taken && (target != pred_target)));
  end

endmodule

// File: rtl/exec_resolve_stage.sv
// exec_resolve_stage: execute-to-memory pipeline register with branch
// resolution and a one-cycle redirect pulse on mispredict.
// Optional build macro EXEC_BRANCH_STATS_EN adds saturating 32-bit
// counters for control instructions, taken ones and mispredicts.
module exec_resolve_stage
  import exec_resolve_stage_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_WIDTH-1:0]  in_alu_out,
  input  logic [BIT_WIDTH-1:0]  in_pc,
  input  logic [BIT_WIDTH-1:0]  in_imm,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic                  in_wr_en,
  input  logic                  in_is_branch,
  input  logic                  in_is_jal,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [BIT_WIDTH-1:0]  in_store_data,
  input  logic                  in_pred_taken,
  input  logic [BIT_WIDTH-1:0]  in_pred_target,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_WIDTH-1:0]  out_result,
  output logic [BIT_WIDTH-1:0]  out_store_data,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  out_wr_en,
  output logic                  out_is_load,
  output logic                  out_is_store,
  output logic                  redirect_valid,
  output logic [BIT_WIDTH-1:0]  redirect_pc
`ifdef EXEC_BRANCH_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_taken,
  output logic [31:0]           stat_mispred
`endif
);

  insn_flags_t          in_flags;
  logic                 accept;
  logic                 br_taken;
  logic                 br_mispredict;
  logic [BIT_WIDTH-1:0] br_target;
  logic [BIT_WIDTH-1:0] fallthrough;
  logic [BIT_WIDTH-1:0] actual_next;

  // Pack the incoming is_* flags into the shared bundle layout.
  always_comb begin
    in_flags              = '0;
    in_flags[FLAG_BRANCH] = in_is_branch;
    in_flags[FLAG_JAL]    = in_is_jal;
    in_flags[FLAG_LOAD]   = in_is_load;
    in_flags[FLAG_STORE]  = in_is_store;
  end

  // Upstream handshake; a flush blocks acceptance outright.
  always_comb begin
    in_ready = !flush && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  branch_resolve #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_branch_resolve (
    .alu_out     (in_alu_out),
    .pc          (in_pc),
    .imm         (in_imm),
    .is_branch   (in_flags[FLAG_BRANCH]),
    .is_jal      (in_flags[FLAG_JAL]),
    .pred_taken  (in_pred_taken),
    .pred_target (in_pred_target),
    .taken       (br_taken),
    .target      (br_target),
    .fallthrough (fallthrough),
    .mispredict  (br_mispredict)
  );

  // Architecturally correct next PC for the accepted instruction.
  always_comb begin
    actual_next = br_taken ? br_target : fallthrough;
  end

  // Pipeline register, valid tracking and redirect pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_dst        <= '0;
      out_wr_en      <= 1'b0;
      out_is_load    <= 1'b0;
      out_is_store   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // accept is already low under flush, so the pulse is suppressed too.
      redirect_valid <= accept && br_mispredict;
      if (accept && br_mispredict) begin
        redirect_pc <= actual_next;
      end
      if (accept) begin
        out_result     <= in_flags[FLAG_JAL] ? fallthrough : in_alu_out;
        out_store_data <= in_store_data;
        out_dst        <= in_dst;
        out_wr_en      <= in_flags[FLAG_JAL] ? in_wr_en
                                             : (in_wr_en && !in_flags[FLAG_BRANCH]);
        out_is_load    <= in_flags[FLAG_LOAD];
        out_is_store   <= in_flags[FLAG_STORE];
      end
    end
  end

`ifdef EXEC_BRANCH_STATS_EN
  // Saturating branch statistics; only real accepts are counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
      stat_mispred  <= '0;
    end else if (accept) begin
      if (in_flags[FLAG_BRANCH] || in_flags[FLAG_JAL]) begin
        stat_branches <= sat_inc(stat_branches);
      end
      if (br_taken) begin
        stat_taken <= sat_inc(stat_taken);
      end
      if (br_mispredict) begin
        stat_mispred <= sat_inc(stat_mispred);
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_resolve_stage.sv
// Scoreboard bench for exec_resolve_stage: the driver pushes expected
// results on each accept, a negedge monitor pops and compares whenever a
// new instruction appears at the output, and checks holding stability.
module tb_exec_resolve_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_alu_out, in_pc, in_imm, in_store_data, in_pred_target;
  logic [3:0]  in_dst;
  logic        in_wr_en, in_is_branch, in_is_jal, in_is_load, in_is_store;
  logic        in_pred_taken, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data, redirect_pc;
  logic [3:0]  out_dst;
  logic        out_wr_en, out_is_load, out_is_store, redirect_valid;
`ifdef EXEC_BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispred;
`endif

  always #5 clk = ~clk;

  exec_resolve_stage #(
    .BIT_WIDTH  (32),
    .REG_ADDR_W (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_out     (in_alu_out),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_dst         (in_dst),
    .in_wr_en       (in_wr_en),
    .in_is_branch   (in_is_branch),
    .in_is_jal      (in_is_jal),
    .in_is_load     (in_is_load),
    .in_is_store    (in_is_store),
    .in_store_data  (in_store_data),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_dst        (out_dst),
    .out_wr_en      (out_wr_en),
    .out_is_load    (out_is_load),
    .out_is_store   (out_is_store),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef EXEC_BRANCH_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
    .stat_mispred   (stat_mispred)
`endif
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu, pc, imm, sd, ptgt;
    logic [3:0]  dst;
    logic        wr_en, br, jal, ld, st, pt, flush, oready;
  } stim_t;

  typedef struct {
    logic [31:0] result, store_data, rpc;
    logic [3:0]  dst;
    logic        wr_en, is_load, is_store, redirect, ctrl, taken;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;
  logic m_valid  = 1'b0;
  logic mon_en   = 1'b0;
  int   m_br = 0, m_tk = 0, m_mp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference: direct reading of the resolution rules.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] fall, tgt;
    fall         = s.pc + 32'd4;
    tgt          = 32'd0;
    e.result     = s.alu;
    e.store_data = s.sd;
    e.dst        = s.dst;
    e.wr_en      = s.wr_en;
    e.is_load    = s.ld;
    e.is_store   = s.st;
    e.ctrl       = s.br || s.jal;
    e.taken      = 1'b0;
    if (s.jal) begin
      e.taken  = 1'b1;
      tgt      = s.alu;
      e.result = fall;
    end else if (s.br) begin
      e.taken = s.alu[0];
      tgt     = fall + s.imm * 32'd4;
      e.wr_en = 1'b0;
    end
    e.redirect = e.ctrl && ((e.taken != s.pt) || (e.taken && tgt != s.ptgt));
    e.rpc      = e.taken ? tgt : fall;
    return e;
  endfunction

  function automatic stim_t idle(input logic oready);
    stim_t s;
    s        = '{default: '0};
    s.oready = oready;
    return s;
  endfunction

  function automatic stim_t ctrl_op(input logic jal, input logic [31:0] pc,
                                    input logic [31:0] imm, input logic [31:0] alu,
                                    input logic pt, input logic [31:0] ptgt,
                                    input logic [3:0] dst, input logic oready);
    stim_t s;
    s        = idle(oready);
    s.valid  = 1'b1;
    s.br     = !jal;
    s.jal    = jal;
    s.pc     = pc;
    s.imm    = imm;
    s.alu    = alu;
    s.pt     = pt;
    s.ptgt   = ptgt;
    s.dst    = dst;
    s.wr_en  = 1'b1;
    s.sd     = 32'hA5A5_0000 | {28'd0, dst};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    op;
    s        = idle($urandom_range(0, 3) != 0);
    s.valid  = $urandom_range(0, 9) < 7;
    s.flush  = $urandom_range(0, 19) == 0;
    s.alu    = $urandom;
    s.pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    s.imm    = 32'($urandom_range(0, 2047)) - 32'd1024;
    s.sd     = $urandom;
    s.dst    = 4'($urandom_range(0, 15));
    s.wr_en  = $urandom_range(0, 1);
    s.pt     = $urandom_range(0, 1);
    op       = $urandom_range(0, 4);
    s.ld     = (op == 1);
    s.st     = (op == 2);
    s.br     = (op == 3);
    s.jal    = (op == 4);
    if ($urandom_range(0, 1) == 1)
      s.ptgt = s.jal ? s.alu : (s.pc + 32'd4 + s.imm * 32'd4);
    else
      s.ptgt = $urandom;
    return s;
  endfunction

  // Drive one cycle of stimulus, check in_ready and push on accept.
  task automatic issue(input stim_t s);
    exp_t e;
    logic rdy_exp, acc;
    @(posedge clk);
    #2;
    in_valid       = s.valid;
    in_alu_out     = s.alu;
    in_pc          = s.pc;
    in_imm         = s.imm;
    in_dst         = s.dst;
    in_wr_en       = s.wr_en;
    in_is_branch   = s.br;
    in_is_jal      = s.jal;
    in_is_load     = s.ld;
    in_is_store    = s.st;
    in_store_data  = s.sd;
    in_pred_taken  = s.pt;
    in_pred_target = s.ptgt;
    flush          = s.flush;
    out_ready      = s.oready;
    #1;
    rdy_exp = !s.flush && (!m_valid || s.oready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
    acc = s.valid && rdy_exp;
    if (acc) begin
      e = model(s);
      exp_q.push_back(e);
      if (e.ctrl)     m_br++;
      if (e.taken)    m_tk++;
      if (e.redirect) m_mp++;
    end
    if (s.flush)       m_valid = 1'b0;
    else if (acc)      m_valid = 1'b1;
    else if (s.oready) m_valid = 1'b0;
  endtask

  task automatic cmp_fields(input string pfx, input exp_t e);
    chk({pfx, "result"},     out_result,               e.result);
    chk({pfx, "store_data"}, out_store_data,           e.store_data);
    chk({pfx, "dst"},        {28'd0, out_dst},         {28'd0, e.dst});
    chk({pfx, "wr_en"},      {31'd0, out_wr_en},       {31'd0, e.wr_en});
    chk({pfx, "is_load"},    {31'd0, out_is_load},     {31'd0, e.is_load});
    chk({pfx, "is_store"},   {31'd0, out_is_store},    {31'd0, e.is_store});
  endtask

  // Monitor: a fresh output pops the scoreboard; a held one must not move.
  initial begin : monitor
    exp_t e;
    logic fresh;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        fresh = out_valid && (!prev_valid || prev_ready);
        if (fresh) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=valid required=no_output");
          end else begin
            e        = exp_q.pop_front();
            last_exp = e;
            cmp_fields("out_", e);
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.redirect});
            if (e.redirect) chk("redirect_pc", redirect_pc, e.rpc);
          end
        end else begin
          chk("redirect_idle", {31'd0, redirect_valid}, 32'd0);
          if (out_valid) cmp_fields("hold_", last_exp);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stimulus
    stim_t s;
    in_valid = 0; in_alu_out = 0; in_pc = 0; in_imm = 0; in_dst = 0;
    in_wr_en = 0; in_is_branch = 0; in_is_jal = 0; in_is_load = 0;
    in_is_store = 0; in_store_data = 0; in_pred_taken = 0;
    in_pred_target = 0; flush = 0; out_ready = 0;
    reset_n = 1'b0;
    #12 reset_n = 1'b1;

    // Reset mid-transfer: a held mispredicting JAL is dropped.
    issue(ctrl_op(1'b1, 32'h40, 32'd0, 32'h200, 1'b0, 32'd0, 4'd5, 1'b0));
    @(posedge clk);
    #1;
    chk("pre_reset_valid",    {31'd0, out_valid},      32'd1);
    chk("pre_reset_redirect", {31'd0, redirect_valid}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_out_valid",   {31'd0, out_valid},      32'd0);
    chk("rst_redirect",    {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc,             32'd0);
    chk("rst_result",      out_result,              32'd0);
    chk("rst_wr_en",       {31'd0, out_wr_en},      32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    m_valid = 1'b0;
    m_br = 0; m_tk = 0; m_mp = 0;
    @(negedge clk);
    mon_en = 1'b1;

    // Branch taken, predicted not-taken -> redirect to 0x110, wr_en dropped.
    issue(ctrl_op(1'b0, 32'h100, 32'd3, 32'd1, 1'b0, 32'd0, 4'd2, 1'b1));
    issue(idle(1'b1));
    // Same branch correctly predicted.
    issue(ctrl_op(1'b0, 32'h100, 32'd3, 32'd1, 1'b1, 32'h110, 4'd2, 1'b1));
    issue(idle(1'b1));
    // JAL: link value pc+4, redirect to ALU target.
    issue(ctrl_op(1'b1, 32'h40, 32'd0, 32'h200, 1'b0, 32'd0, 4'd5, 1'b1));
    issue(idle(1'b1));
    // Back-to-back mispredicts.
    issue(ctrl_op(1'b0, 32'h300, 32'hFFFF_FFFE, 32'd1, 1'b0, 32'd0, 4'd1, 1'b1));
    issue(ctrl_op(1'b0, 32'h304, 32'd8, 32'd0, 1'b1, 32'h328, 4'd1, 1'b1));
    issue(idle(1'b1));

    // Backpressure: hold for three cycles, then the waiting one loads.
    issue(ctrl_op(1'b1, 32'h500, 32'd0, 32'h800, 1'b1, 32'h800, 4'd7, 1'b1));
    s = ctrl_op(1'b1, 32'h504, 32'd0, 32'h900, 1'b0, 32'd0, 4'd9, 1'b0);
    for (int i = 0; i < 3; i++) issue(s);
    s.oready = 1'b1;
    issue(s);
    issue(idle(1'b1));

    // Flush against a held instruction and a mispredicting accept.
    issue(ctrl_op(1'b1, 32'h600, 32'd0, 32'h640, 1'b1, 32'h640, 4'd3, 1'b0));
    s = ctrl_op(1'b0, 32'h700, 32'd4, 32'd1, 1'b0, 32'd0, 4'd4, 1'b1);
    s.flush = 1'b1;
    issue(s);
    issue(idle(1'b1));
    issue(idle(1'b1));
`ifdef EXEC_BRANCH_STATS_EN
    #1;
    chk("stat_branches_flush", stat_branches, m_br);
    chk("stat_mispred_flush",  stat_mispred,  m_mp);
`endif

    // Randomized traffic.
    for (int n = 0; n < 300; n++) issue(rand_stim());

    for (int i = 0; i < 4; i++) issue(idle(1'b1));
    @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
`ifdef EXEC_BRANCH_STATS_EN
    chk("stat_branches", stat_branches, m_br);
    chk("stat_taken",    stat_taken,    m_tk);
    chk("stat_mispred",  stat_mispred,  m_mp);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
